// File: rtl/cnn_pkg.sv
// Shared state type and sizing/limit helpers for the CNN multiply-accumulate datapath.
package cnn_pkg;

  typedef enum logic {ACCUM, HOLD} mac_state_e;

  function automatic int acc_width(int bit_size, int weight_bits, int kernel_size);
    return bit_size + weight_bits + $clog2(kernel_size) + 1;
  endfunction

  // Clamp limits for a signed bit_size-wide result, held in 64 bits and sliced by the user.
  function automatic logic signed [63:0] sat_max(int bit_size);
    return (64'sd1 <<< (bit_size - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(int bit_size);
    return -(64'sd1 <<< (bit_size - 1));
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One signed activation x weight product at full precision; purely combinational.
module mac_lane_mult #(
  parameter int BitSize    = 32,
  parameter int WeightBits = 4
) (
  input  logic signed [BitSize-1:0]            a,
  input  logic signed [WeightBits-1:0]         w,
  output logic signed [BitSize+WeightBits-1:0] p
);

  localparam int ProdBits = BitSize + WeightBits;

  logic signed [ProdBits-1:0] a_ext;
  logic signed [ProdBits-1:0] w_ext;

  // Both operands widened to the product width so the multiply never truncates.
  assign a_ext = {{WeightBits{a[BitSize-1]}}, a};
  assign w_ext = {{BitSize{w[WeightBits-1]}}, w};
  assign p     = a_ext * w_ext;

endmodule

// File: rtl/mac_multiprecision.sv
// Pipelined multi-lane MAC: accumulates KernelSize products into one shifted output pixel.
// Define MAC_SATURATE_EN to clamp overflowing results instead of truncating them.
module mac_multiprecision
  import cnn_pkg::*;
#(
  parameter int BitSize       = 32,
  parameter int WeightBits    = 4,
  parameter int FixedPointPos = 0,
  parameter int KernelSize    = 9,
  parameter int Lanes         = 1
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [Lanes*BitSize-1:0]      in_data,
  input  logic [Lanes*WeightBits-1:0]   in_weight,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [BitSize-1:0]     out_data,
  output logic                          out_overflow
);

  localparam int AccBits  = acc_width(BitSize, WeightBits, KernelSize);
  localparam int ProdBits = BitSize + WeightBits;
  localparam int Beats    = KernelSize / Lanes;
  localparam int CntBits  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntBits-1:0] LastCnt = CntBits'(Beats - 1);

  if (KernelSize % Lanes != 0) begin : g_bad_kernel
    $error("mac_multiprecision: KernelSize must be a multiple of Lanes");
  end
  if (WeightBits < 1 || WeightBits > 8) begin : g_bad_weight
    $error("mac_multiprecision: WeightBits must be in 1..8");
  end

  logic signed [ProdBits-1:0]      prod [Lanes];
  logic signed [AccBits-1:0]       lane_sum;
  logic signed [AccBits-1:0]       acc_sum;
  logic signed [AccBits-1:0]       final_sum;
  logic [AccBits-BitSize:0]        upper_bits;
  logic                            overflow;
  logic signed [BitSize-1:0]       result;
  logic                            fire;

  mac_state_e                      state_q, state_d;
  logic [CntBits-1:0]              cnt_q, cnt_d;
  logic signed [AccBits-1:0]       acc_q, acc_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic signed [BitSize-1:0]       out_data_q, out_data_d;
  logic                            out_overflow_q, out_overflow_d;

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    mac_lane_mult #(
      .BitSize    (BitSize),
      .WeightBits (WeightBits)
    ) u_mult (
      .a (in_data[l*BitSize +: BitSize]),
      .w (in_weight[l*WeightBits +: WeightBits]),
      .p (prod[l])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < Lanes; l++) begin
      lane_sum = lane_sum + {{(AccBits-ProdBits){prod[l][ProdBits-1]}}, prod[l]};
    end
  end

  assign acc_sum   = acc_q + lane_sum;
  assign final_sum = acc_sum >>> FixedPointPos;

  // Fits only if everything from bit BitSize-1 upward is a pure sign extension.
  assign upper_bits = final_sum[AccBits-1:BitSize-1];
  assign overflow   = !((&upper_bits) || !(|upper_bits));

`ifdef MAC_SATURATE_EN
  localparam logic signed [63:0] SatMax = sat_max(BitSize);
  localparam logic signed [63:0] SatMin = sat_min(BitSize);

  always_comb begin
    result = final_sum[BitSize-1:0];
    if (overflow) begin
      result = final_sum[AccBits-1] ? SatMin[BitSize-1:0] : SatMax[BitSize-1:0];
    end
  end
`else
  assign result = final_sum[BitSize-1:0];
`endif

  assign fire = in_valid && in_ready_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_overflow_d = out_overflow_q;
    case (state_q)
      ACCUM: begin
        if (fire) begin
          if (cnt_q == LastCnt) begin
            out_data_d     = result;
            out_overflow_d = overflow;
            out_valid_d    = 1'b1;
            in_ready_d     = 1'b0;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = HOLD;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CntBits'(1);
          end
        end
      end
      HOLD: begin
        // Leaving HOLD only re-arms in_ready; the next beat is taken a cycle later.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d    = ACCUM;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q        <= ACCUM;
      cnt_q          <= '0;
      acc_q          <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_mac_multiprecision.sv
// Directed bench for mac_multiprecision across several parameter sets (default, fixed-point, 8-bit, 3-lane, single-beat).
module tb_mac_multiprecision;

`ifdef MAC_SATURATE_EN
  localparam int ExpBPos = 127;
  localparam int ExpBNeg = -128;
`else
  localparam int ExpBPos = 65;
  localparam int ExpBNeg = 121;
`endif

  logic clk = 1'b0;
  logic res = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  // Lockstep group of Lanes=1, KernelSize=9 instances sharing valid/ready.
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [31:0]        data_a = '0, data_f = '0;
  logic [7:0]         data_b = '0;
  logic [3:0]         w_a = '0, w_f = '0, w_b = '0;
  logic               ready_a, ready_f, ready_b;
  logic               valid_a, valid_f, valid_b;
  logic signed [31:0] out_a, out_f;
  logic signed [7:0]  out_b;
  logic               ovf_a, ovf_f, ovf_b;

  // Three-lane instance.
  logic               in_valid_l = 1'b0;
  logic               out_ready_l = 1'b0;
  logic [95:0]        data_l = '0;
  logic [11:0]        w_l = '0;
  logic               ready_l, valid_l, ovf_l;
  logic signed [31:0] out_l;

  // Single-beat instance (KernelSize == Lanes == 1).
  logic               in_valid_s = 1'b0;
  logic               out_ready_s = 1'b0;
  logic [31:0]        data_s = '0;
  logic [3:0]         w_s = '0;
  logic               ready_s, valid_s, ovf_s;
  logic signed [31:0] out_s;

  mac_multiprecision dut_a (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(data_a), .in_weight(w_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(out_a), .out_overflow(ovf_a));

  mac_multiprecision #(.FixedPointPos(2)) dut_f (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ready_f),
    .in_data(data_f), .in_weight(w_f), .out_valid(valid_f), .out_ready(out_ready),
    .out_data(out_f), .out_overflow(ovf_f));

  mac_multiprecision #(.BitSize(8)) dut_b (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(ready_b),
    .in_data(data_b), .in_weight(w_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(out_b), .out_overflow(ovf_b));

  mac_multiprecision #(.Lanes(3)) dut_l (
    .clk(clk), .res(res), .in_valid(in_valid_l), .in_ready(ready_l),
    .in_data(data_l), .in_weight(w_l), .out_valid(valid_l), .out_ready(out_ready_l),
    .out_data(out_l), .out_overflow(ovf_l));

  mac_multiprecision #(.KernelSize(1)) dut_s (
    .clk(clk), .res(res), .in_valid(in_valid_s), .in_ready(ready_s),
    .in_data(data_s), .in_weight(w_s), .out_valid(valid_s), .out_ready(out_ready_s),
    .out_data(out_s), .out_overflow(ovf_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    #12;
    tests_run++; if (ready_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ready_a); end
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", valid_a); end
    tests_run++; if (out_a !== 32'sd0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_a); end
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b expected 0", ovf_a); end
    tests_run++; if (valid_l !== 1'b0 || ready_l !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_lanes3: got valid=%b ready=%b expected valid=0 ready=1", valid_l, ready_l); end
    tests_run++; if (valid_s !== 1'b0 || ready_s !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_single: got valid=%b ready=%b expected valid=0 ready=1", valid_s, ready_s); end
    res = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    data_a = 32'd10;  w_a = 4'd1;
    data_f = 32'd7;   w_f = 4'd2;
    data_b = 8'd127;  w_b = 4'd7;
    in_valid = 1'b1;
    repeat (8) tick();
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid: got %b expected 0", valid_a); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid: got %b expected 1", valid_a); end
    tests_run++; if (out_a !== 32'sd90) begin tests_failed++; $display("[TB] FAIL basic_data: got %0d expected 90", out_a); end
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_overflow: got %b expected 0", ovf_a); end
    tests_run++; if (ready_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_hold_ready: got %b expected 0", ready_a); end
    tests_run++; if (out_f !== 32'sd31) begin tests_failed++; $display("[TB] FAIL fixed_point_pos: got %0d expected 31", out_f); end
    tests_run++; if (out_b !== 8'(ExpBPos)) begin tests_failed++; $display("[TB] FAIL narrow_pos_data: got %0d expected %0d", out_b, ExpBPos); end
    tests_run++; if (ovf_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL narrow_pos_overflow: got %b expected 1", ovf_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++; if (valid_a !== 1'b0 || ready_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_release: got valid=%b ready=%b expected valid=0 ready=1", valid_a, ready_a); end
  endtask

  task automatic test_negative();
    data_a = 32'd3;          w_a = 4'b1000;
    data_f = 32'hFFFF_FFFB;  w_f = 4'd2;
    data_b = 8'hFD;          w_b = 4'd5;
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0;
    tests_run++; if (out_a !== -32'sd216) begin tests_failed++; $display("[TB] FAIL neg_weight_data: got %0d expected -216", out_a); end
    tests_run++; if (ovf_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL neg_weight_overflow: got %b expected 0", ovf_a); end
    tests_run++; if (out_f !== -32'sd23) begin tests_failed++; $display("[TB] FAIL neg_floor_shift: got %0d expected -23", out_f); end
    tests_run++; if (out_b !== 8'(ExpBNeg)) begin tests_failed++; $display("[TB] FAIL narrow_neg_data: got %0d expected %0d", out_b, ExpBNeg); end
    tests_run++; if (ovf_b !== 1'b1) begin tests_failed++; $display("[TB] FAIL narrow_neg_overflow: got %b expected 1", ovf_b); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    data_a = 32'd2; w_a = 4'd3;
    data_f = 32'd4; w_f = 4'd1;
    data_b = 8'd1;  w_b = 4'd1;
    in_valid = 1'b1;
    repeat (9) tick();
    tests_run++; if (out_a !== 32'sd54) begin tests_failed++; $display("[TB] FAIL bp_first_data: got %0d expected 54", out_a); end
    tests_run++; if (out_b !== 8'sd9 || ovf_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_narrow_fit: got %0d ovf=%b expected 9 ovf=0", out_b, ovf_b); end
    data_a = 32'd5; w_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (ready_a !== 1'b0 || valid_a !== 1'b1 || out_a !== 32'sd54) begin tests_failed++; $display("[TB] FAIL bp_stall_%0d: got ready=%b valid=%b data=%0d expected ready=0 valid=1 data=54", i, ready_a, valid_a, out_a); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++; if (ready_a !== 1'b1 || valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", ready_a, valid_a); end
    repeat (8) tick();
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_no_passthrough: got valid=%b expected 0", valid_a); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (valid_a !== 1'b1 || out_a !== -32'sd45) begin tests_failed++; $display("[TB] FAIL bp_second_data: got valid=%b data=%0d expected valid=1 data=-45", valid_a, out_a); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    data_a = 32'd1; w_a = 4'd1;
    data_f = 32'd1; w_f = 4'd1;
    data_b = 8'd1;  w_b = 4'd1;
    in_valid = 1'b1;
    repeat (4) tick();
    res = 1'b1;
    #1;
    tests_run++; if (ready_a !== 1'b1 || valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_state: got ready=%b valid=%b expected ready=1 valid=0", ready_a, valid_a); end
    #1;
    res = 1'b0;
    repeat (8) tick();
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_reset_early: got valid=%b expected 0", valid_a); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (valid_a !== 1'b1 || out_a !== 32'sd9) begin tests_failed++; $display("[TB] FAIL mid_reset_data: got valid=%b data=%0d expected valid=1 data=9", valid_a, out_a); end
    tests_run++; if (out_f !== 32'sd2) begin tests_failed++; $display("[TB] FAIL mid_reset_shift: got %0d expected 2", out_f); end
    res = 1'b1;
    #1;
    tests_run++; if (valid_a !== 1'b0 || out_a !== 32'sd0) begin tests_failed++; $display("[TB] FAIL hold_reset: got valid=%b data=%0d expected valid=0 data=0", valid_a, out_a); end
    #1;
    res = 1'b0;
    tick();
  endtask

  task automatic test_lanes();
    data_l = {32'd10, 32'd10, 32'd10};
    w_l    = {4'd1, 4'd1, 4'd1};
    in_valid_l = 1'b1;
    repeat (2) tick();
    tests_run++; if (valid_l !== 1'b0) begin tests_failed++; $display("[TB] FAIL lanes_early: got valid=%b expected 0", valid_l); end
    tick();
    in_valid_l = 1'b0;
    tests_run++; if (valid_l !== 1'b1 || out_l !== 32'sd90) begin tests_failed++; $display("[TB] FAIL lanes_uniform: got valid=%b data=%0d expected valid=1 data=90", valid_l, out_l); end
    out_ready_l = 1'b1;
    tick();
    out_ready_l = 1'b0;
    data_l = {32'hFFFF_FFFB, 32'd10, 32'd3};
    w_l    = {4'd2, 4'd1, 4'b1000};
    in_valid_l = 1'b1;
    repeat (3) tick();
    in_valid_l = 1'b0;
    tests_run++; if (valid_l !== 1'b1 || out_l !== -32'sd72) begin tests_failed++; $display("[TB] FAIL lanes_mixed: got valid=%b data=%0d expected valid=1 data=-72", valid_l, out_l); end
    out_ready_l = 1'b1;
    tick();
    out_ready_l = 1'b0;
  endtask

  task automatic test_single_beat();
    data_s = 32'd5; w_s = 4'b1101;
    in_valid_s = 1'b1;
    tick();
    tests_run++; if (valid_s !== 1'b1 || out_s !== -32'sd15 || ready_s !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_first: got valid=%b data=%0d ready=%b expected valid=1 data=-15 ready=0", valid_s, out_s, ready_s); end
    data_s = 32'd6; w_s = 4'd7;
    out_ready_s = 1'b1;
    tick();
    out_ready_s = 1'b0;
    tests_run++; if (valid_s !== 1'b0 || ready_s !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_release: got valid=%b ready=%b expected valid=0 ready=1", valid_s, ready_s); end
    tick();
    in_valid_s = 1'b0;
    tests_run++; if (valid_s !== 1'b1 || out_s !== 32'sd42) begin tests_failed++; $display("[TB] FAIL single_second: got valid=%b data=%0d expected valid=1 data=42", valid_s, out_s); end
    out_ready_s = 1'b1;
    tick();
    out_ready_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_lanes();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mac_multiprecision.md
Name: mac_multiprecision

Overview:
- Parameterised, pipelined multiply-accumulate engine for the CNN convolution datapath. Successor to the single-product 4-bit weight multiplier.
- Accepts a stream of activation/weight beats, `Lanes` products per beat, and accumulates `KernelSize` products into one output pixel.
- Weight precision (`WeightBits`) and fixed-point position are compile-time parameters.
- Sits between the line-buffer/window generator and the activation/pooling stage.

Parameters:
- BitSize, 32, activation and output data width (signed two's complement).
- WeightBits, 4, signed fixed-point weight width; legal values 1..8.
- FixedPointPos, 0, arithmetic right shift applied to the final sum.
- KernelSize, 9, products per output. KernelSize % Lanes must be 0 (elaboration-time assertion).
- Lanes, 1, products per input beat.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  asynchronous active-high reset.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  Lanes*BitSize  packed signed activations; lane 0 in the LSBs.
- in_weight  in  Lanes*WeightBits  packed signed weights; lane 0 in the LSBs.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  BitSize  signed result.
- out_overflow  out  1  shifted sum did not fit in BitSize; qualified by out_valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state ACCUM, beat counter 0, accumulator 0, in_ready 1, out_valid 0, out_data 0, out_overflow 0.
- Accumulator width: AccBits = BitSize + WeightBits + $clog2(KernelSize) + 1. No internal wrap is possible.
- Beats per output: Beats = KernelSize/Lanes.
- Products: each lane computes the full-width signed product in_data[l] * in_weight[l] (BitSize+WeightBits bits). Lane products are sign-extended and summed into the accumulator.
- State ACCUM:
  - in_ready = 1.
  - On each handshake: acc <= acc + lane_sum; cnt <= cnt + 1.
  - On the handshake where cnt == Beats-1:
    - Compute final = (acc + lane_sum) >>> FixedPointPos (arithmetic shift).
    - Register the final result into out_data/out_overflow and set out_valid.
    - Clear acc and cnt; go to HOLD.
  - With no handshake, state is unchanged.
- Latency: out_valid rises the cycle after the last beat is accepted.
- State HOLD:
  - in_ready = 0; out_data and out_valid are stable until out_ready.
  - On out_ready: clear out_valid, go to ACCUM. The next beat is accepted no earlier than the following cycle (no same-cycle pass-through).
- Truncation (macro absent): out_data = final[BitSize-1:0]. out_overflow is still computed: 1 if the bits above BitSize-1 are not a sign extension of bit BitSize-1.
- Beats=1 (KernelSize==Lanes): every accepted beat goes directly to HOLD.
- Reset mid-accumulation: partial sum is discarded; the next accepted beat is beat 0.
- Reset in HOLD: the pending result is lost and out_valid drops immediately (asynchronous).
- WeightBits=1: the weight range is {-1,0}; no special casing.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: when the final value overflows, out_data clamps to +2^(BitSize-1)-1 or -2^(BitSize-1) by sign. out_overflow still flags the event.
- Undefined: two's-complement truncation as above.
- Handshake and latency are identical in both builds.

Decomposition:
- Package cnn_pkg holds:
  - the acc_width() function (AccBits formula);
  - the state enum typedef {ACCUM, HOLD};
  - the saturation-limit constants as functions of BitSize.
- One sub-module: mac_lane_mult (signed BitSize x WeightBits product, combinational), instantiated Lanes times via generate.
- The adder tree and FSM live in the top module.

Test Plan:
- Defaults, 9 beats, in_data=10, weight=1 -> one out_valid pulse, out_data=90, out_overflow=0, one cycle after beat 9.
- Weight -8 (4'b1000), in_data=3, 9 beats -> out_data=-216; sign handling of the most-negative weight.
- FixedPointPos=2, weight=2 (0.5), in_data=7, 9 beats -> sum 126 >>> 2 = 31; odd input -5 x 2 x 9 = -90 >>> 2 = -23 (floor).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable; then out_ready=1 -> in_ready returns the next cycle; no beat dropped.
- Reset asserted after 4 beats, released, 9 fresh beats of 1x1 -> out_data=9, not 13.
- BitSize=8, in_data=127, weight=7, 9 beats (sum 8001):
  - with MAC_SATURATE_EN: out_data=127, out_overflow=1;
  - without: out_data=8001 mod 256 = 65 (0x41), out_overflow=1.
- Lanes=3, KernelSize=9 -> 3 beats per output, same result as Lanes=1 for identical data.
